vec3_div_scalar: RTL
====================

Name: vec3_div_scalar

Overview:
- Sequential fixed-point divider. Computes the inverse of vector scaling: each component of a vec3 is divided by one signed scalar.
- Feeds ray-marcher stages that need direction normalisation and distance ratios, where a combinational divide would not close timing.
- Three identical radix-2 restoring dividers run in lockstep.
- Valid/ready handshake on both the input and output sides.

Parameters:
- WORD_WIDTH, 32: width of each fixed-point word (signed two's complement).
- FRAC_BITS, 16: fractional bits of the format (Q15.16 default).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- in_vec  in  3*WORD_WIDTH  packed {x,y,z}, x in MSBs.
- in_s  in  WORD_WIDTH  signed divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_vec  out  3*WORD_WIDTH  packed {x,y,z} quotients.
- div_by_zero  out  1  set with out_valid when in_s was 0.
- overflow  out  3  per-component saturation flag; bit2=x, bit1=y, bit0=z.

Behaviour:
- Function per component: q = trunc((a << FRAC_BITS) / s). Rounds toward zero; the result is in the same Q format.
- Reset (rst sampled high at a clk edge):
  - State goes to IDLE; the current operation is aborted and its result discarded.
  - out_valid=0, out_vec=0, div_by_zero=0, overflow=0.
  - in_ready is 0 while rst is high and 1 from the first cycle with rst low.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready the block captures the operands, computes the sign of each component (sign(a) XOR sign(s)), computes the magnitudes |a| and |s| as WORD_WIDTH-bit unsigned values (|-2^(W-1)| = 2^(W-1) exactly), loads the dividend |a|<<FRAC_BITS (WORD_WIDTH+FRAC_BITS bits) and goes to DIV.
  - DIV: one quotient bit per cycle for each component, remainder WORD_WIDTH+1 bits. An iteration counter runs from WORD_WIDTH+FRAC_BITS-1 down to 0; at 0 the block goes to FIX.
  - FIX: applies sign and saturation and registers out_vec and the flags, then goes to DONE.
  - DONE: out_valid=1; out_vec and flags stay stable until out_ready. On out_valid&out_ready the block goes to IDLE; in_ready rises the following cycle (no same-cycle re-accept).
- Latency:
  - From the accept edge to out_valid high is WORD_WIDTH+FRAC_BITS+2 cycles (50 at defaults).
  - Latency is fixed and independent of the data, including the divide-by-zero case.
- Saturation (FIX state):
  - Unsigned quotient is WORD_WIDTH+FRAC_BITS bits.
  - Positive result with magnitude > 2^(W-1)-1 gives 0x7FFF_FFFF and sets overflow[i].
  - Negative result with magnitude > 2^(W-1) gives 0x8000_0000 and sets overflow[i].
  - Negative result with magnitude exactly 2^(W-1) gives 0x8000_0000 with no overflow flag.
  - A zero quotient is never negative, so -0 is emitted as 0.
- Divide by zero (in_s==0):
  - div_by_zero=1 and overflow bits clear.
  - Each component: a>0 gives 0x7FFF_FFFF, a<0 gives 0x8000_0000, a==0 gives 0.
  - The divider datapath may run on garbage; FIX overrides the result.
- Inputs are ignored outside IDLE. in_vec and in_s may change freely after acceptance.
- out_ready while out_valid=0 has no effect.

Test Plan:
- Basic: in_vec={0x00030000, 0xFFFE8000, 0x00008000} (3.0, -1.5, 0.5), in_s=0x00020000 (2.0) -> out_vec={0x00018000, 0xFFFF4000, 0x00004000}. out_valid exactly 50 cycles after accept; flags 0.
- Truncation toward zero: x=0x00010000, y=0xFFFF0000, z=0 with s=0x00030000 -> x=0x00005555, y=0xFFFFAAAB, z=0x00000000.
- Overflow and edges:
  - x=0x40000000, s=0x00000100 -> 0x7FFFFFFF, overflow[2]=1.
  - Same x with s=0xFFFFFF00 -> 0x80000000, overflow[2]=1.
  - x=0x80000000, s=0x00010000 -> 0x80000000, no flag.
- Divide by zero: in_vec={0x00010000, 0xFFFF0000, 0}, s=0 -> {0x7FFFFFFF, 0x80000000, 0x00000000}, div_by_zero=1, overflow=0.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid -> out_vec stable and in_ready=0 throughout. Pulse out_ready -> in_ready=1 the next cycle. A second in_valid during DIV is ignored.
- Reset mid-operation: assert rst for 1 cycle during DIV cycle 20 -> out_valid stays 0 and in_ready=1 after rst drops. A new operation (1.0/3.0) gives 0x00005555 with full latency.

Source files
------------

// File: rtl/vec3_div_scalar.sv
// vec3_div_scalar: divides each component of a signed fixed-point vec3 by one
// signed scalar using three lockstep radix-2 restoring dividers.
// Result per component is trunc((a << FRAC_BITS) / s), saturated to WORD_WIDTH.
module vec3_div_scalar #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned FRAC_BITS  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3*WORD_WIDTH-1:0] in_vec,
  input  logic [WORD_WIDTH-1:0]   in_s,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3*WORD_WIDTH-1:0] out_vec,
  output logic                    div_by_zero,
  output logic [2:0]              overflow
);

  localparam int unsigned W  = WORD_WIDTH;
  localparam int unsigned QW = WORD_WIDTH + FRAC_BITS;
  localparam int unsigned CW = $clog2(QW);

  // Largest representable positive / negative magnitudes, in quotient width
  localparam logic [QW-1:0] POS_LIM = {{(FRAC_BITS + 1){1'b0}}, {(W - 1){1'b1}}};
  localparam logic [QW-1:0] NEG_LIM = {{FRAC_BITS{1'b0}}, 1'b1, {(W - 1){1'b0}}};
  localparam logic [W-1:0]  W_MAX   = {1'b0, {(W - 1){1'b1}}};
  localparam logic [W-1:0]  W_MIN   = {1'b1, {(W - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    dvsr;
  logic            dz;
  logic [QW-1:0]   qd  [3];
  logic [W-1:0]    rem [3];
  logic [2:0]      q_neg;
  logic [2:0]      a_neg;
  logic [2:0]      a_nz;

  logic            accept;
  logic [W-1:0]    a_mag   [3];
  logic [W:0]      trial   [3];
  logic [2:0]      ge;
  logic [W-1:0]    rem_nxt [3];
  logic [QW-1:0]   qd_nxt  [3];
  logic [3*W-1:0]  res_vec;
  logic [2:0]      res_ovf;

  // Ready only in IDLE and never while reset is asserted
  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  // Operand magnitudes; the most negative word maps to 2^(W-1) exactly
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      a_mag[k] = in_vec[k*W + W - 1] ? (W'(0) - in_vec[k*W +: W]) : in_vec[k*W +: W];
    end
  end

  // One restoring step per component: shift in next dividend bit, trial subtract
  always_comb begin
    ge = '0;
    for (int k = 0; k < 3; k++) begin
      trial[k]   = {rem[k], qd[k][QW-1]};
      ge[k]      = (trial[k] >= {1'b0, dvsr});
      rem_nxt[k] = ge[k] ? W'(trial[k] - {1'b0, dvsr}) : W'(trial[k]);
      qd_nxt[k]  = {qd[k][QW-2:0], ge[k]};
    end
  end

  // Sign application, saturation and divide-by-zero override
  always_comb begin
    res_vec = '0;
    res_ovf = '0;
    for (int k = 0; k < 3; k++) begin
      if (dz) begin
        if (a_nz[k]) res_vec[k*W +: W] = a_neg[k] ? W_MIN : W_MAX;
      end else if (q_neg[k] && (qd[k] != '0)) begin
        if (qd[k] > NEG_LIM) begin
          res_vec[k*W +: W] = W_MIN;
          res_ovf[k]        = 1'b1;
        end else begin
          res_vec[k*W +: W] = W'(0) - qd[k][W-1:0];
        end
      end else if (qd[k] > POS_LIM) begin
        res_vec[k*W +: W] = W_MAX;
        res_ovf[k]        = 1'b1;
      end else begin
        res_vec[k*W +: W] = qd[k][W-1:0];
      end
    end
  end

  // Divider datapath: load on accept, iterate while in DIV
  always_ff @(posedge clk) begin
    if (accept) begin
      dvsr <= in_s[W-1] ? (W'(0) - in_s) : in_s;
      dz   <= (in_s == '0);
      for (int k = 0; k < 3; k++) begin
        qd[k]    <= {a_mag[k], {FRAC_BITS{1'b0}}};
        rem[k]   <= '0;
        a_neg[k] <= in_vec[k*W + W - 1];
        a_nz[k]  <= (in_vec[k*W +: W] != '0);
        q_neg[k] <= in_vec[k*W + W - 1] ^ in_s[W-1];
      end
    end else if (state == DIV) begin
      for (int k = 0; k < 3; k++) begin
        qd[k]  <= qd_nxt[k];
        rem[k] <= rem_nxt[k];
      end
    end
  end

  // Control FSM with registered result and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      out_valid   <= 1'b0;
      out_vec     <= '0;
      div_by_zero <= 1'b0;
      overflow    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt   <= CW'(QW - 1);
            state <= DIV;
          end
        end
        DIV: begin
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - CW'(1);
        end
        FIX: begin
          out_vec     <= res_vec;
          overflow    <= dz ? 3'b000 : res_ovf;
          div_by_zero <= dz;
          state       <= DONE;
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
